blur_5x5: RTL and testbench

Streaming 5x5 Gaussian blur for raster-order RGB video, one pixel per clock, sitting between the camera pixel path and downstream display/processing.
- Four internal line buffers and a 5x5 window per channel.
- Emits one blurred pixel per accepted input pixel once a full 5x5 window lies inside the frame.
- `rd_flag` marks each valid output.

---
 rtl/blur_pkg.sv | 8 +
 rtl/line_buffer.sv | 23 ++
 rtl/blur_5x5.sv | 146 ++++++++++++++
 tb/tb_blur_5x5.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/blur_pkg.sv
// Shared constants for the 5x5 Gaussian blur: kernel taps and fixed-point rounding.
package blur_pkg;
    localparam int PIX_W_DEF = 8;
    localparam int SUM_W     = 16;
    localparam int ROUND     = 128;
    localparam int SHIFT     = 8;
    localparam int KERNEL [5] = '{1, 4, 6, 4, 1};
endpackage

// File: rtl/line_buffer.sv
// One video line of storage; combinational read so the old word is seen while the new one is written.
module line_buffer #(
    parameter int DEPTH = 640,
    parameter int DW    = 24,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] rd_data
);
    logic [DW-1:0] mem_q [DEPTH];

    assign rd_data = mem_q[addr];

    // Contents are left uninitialised; only rows >= 4 of a frame are ever used.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wr_data;
        end
    end
endmodule

// File: rtl/blur_5x5.sv
// Streaming 5x5 Gaussian blur on RGB raster video: line buffers, 5x5 window,
// then a two-stage separable adder tree (column sums, then row sum with rounding).
module blur_5x5
    import blur_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int PIX_W      = PIX_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [PIX_W-1:0] input_pixel_R,
    input  logic [PIX_W-1:0] input_pixel_G,
    input  logic [PIX_W-1:0] input_pixel_B,
    output logic [PIX_W-1:0] output_pixel_R,
    output logic [PIX_W-1:0] output_pixel_G,
    output logic [PIX_W-1:0] output_pixel_B,
    output logic             rd_flag
);
    localparam int DW = 3 * PIX_W;
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic             v1_q, v1_d, v2_q, v2_d, rd_flag_q, rd_flag_d;
    logic [DW-1:0]    pix_in;
    logic [DW-1:0]    lb_rd [4];
    logic [DW-1:0]    lb_wr [4];
    // win_q[col][row]: col 4 is the newest column, row 4 the current line.
    logic [DW-1:0]    win_q [5][5];
    logic [DW-1:0]    win_d [5][5];
    logic [SUM_W-1:0] vsum_q [5][3];
    logic [SUM_W-1:0] vsum_d [5][3];
    logic [SUM_W-1:0] hsum [3];
    logic [SUM_W-1:0] rnd [3];
    logic [PIX_W-1:0] out_q [3];
    logic [PIX_W-1:0] out_d [3];

    assign pix_in = {input_pixel_B, input_pixel_G, input_pixel_R};

    always_comb begin
        lb_wr[0] = pix_in;
        for (int i = 1; i < 4; i++) begin
            lb_wr[i] = lb_rd[i-1];
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_lb
        line_buffer #(.DEPTH(IMG_WIDTH), .DW(DW), .AW(CW)) u_lb (
            .clk     (clk),
            .we      (en),
            .addr    (col_q),
            .wr_data (lb_wr[i]),
            .rd_data (lb_rd[i])
        );
    end

    // Stage 1: raster counters, window shift, window-valid decision.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        v1_d  = 1'b0;
        win_d = win_q;
        if (en) begin
            v1_d = (row_q >= RW'(4)) && (col_q >= CW'(4));
            if (col_q == CW'(IMG_WIDTH - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(IMG_HEIGHT - 1)) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            for (int c = 0; c < 4; c++) begin
                win_d[c] = win_q[c+1];
            end
            win_d[4][0] = lb_rd[3];
            win_d[4][1] = lb_rd[2];
            win_d[4][2] = lb_rd[1];
            win_d[4][3] = lb_rd[0];
            win_d[4][4] = pix_in;
        end
    end

    // Stage 2: vertical weighted sum of each window column, per channel.
    always_comb begin
        v2_d = v1_q;
        for (int c = 0; c < 5; c++) begin
            for (int ch = 0; ch < 3; ch++) begin
                vsum_d[c][ch] = '0;
                for (int r = 0; r < 5; r++) begin
                    vsum_d[c][ch] = vsum_d[c][ch]
                        + SUM_W'(KERNEL[r]) * SUM_W'(win_q[c][r][ch*PIX_W +: PIX_W]);
                end
            end
        end
    end

    // Stage 3: horizontal weighted sum, round to nearest, hold when not valid.
    always_comb begin
        rd_flag_d = v2_q;
        for (int ch = 0; ch < 3; ch++) begin
            hsum[ch] = '0;
            for (int c = 0; c < 5; c++) begin
                hsum[ch] = hsum[ch] + SUM_W'(KERNEL[c]) * vsum_q[c][ch];
            end
            rnd[ch]   = hsum[ch] + SUM_W'(ROUND);
            out_d[ch] = v2_q ? PIX_W'(rnd[ch] >> SHIFT) : out_q[ch];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q     <= '0;
            row_q     <= '0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            rd_flag_q <= 1'b0;
            for (int c = 0; c < 5; c++) begin
                for (int r = 0; r < 5; r++) begin
                    win_q[c][r] <= '0;
                end
                for (int ch = 0; ch < 3; ch++) begin
                    vsum_q[c][ch] <= '0;
                end
            end
            for (int ch = 0; ch < 3; ch++) begin
                out_q[ch] <= '0;
            end
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            rd_flag_q <= rd_flag_d;
            win_q     <= win_d;
            vsum_q    <= vsum_d;
            out_q     <= out_d;
        end
    end

    assign output_pixel_R = out_q[0];
    assign output_pixel_G = out_q[1];
    assign output_pixel_B = out_q[2];
    assign rd_flag        = rd_flag_q;
endmodule

// File: tb/tb_blur_5x5.sv
// Scoreboard bench for blur_5x5 on a reduced 16x10 frame: expected pixels come from a
// direct 2-D convolution of the stimulus image and are popped as rd_flag pulses arrive.
module tb_blur_5x5;
    localparam int W = 16;
    localparam int H = 10;
    localparam int NOUT = (W - 4) * (H - 4);

    typedef struct {
        logic [23:0] pix;
        int          r;
        int          c;
        int          t;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] in_r = '0, in_g = '0, in_b = '0;
    logic [7:0] out_r, out_g, out_b;
    logic       rd_flag;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          n_out = 0;
    exp_t        sb[$];
    exp_t        e_mon;
    logic [23:0] img [H][W];
    logic [7:0]  got_r [H][W];
    logic [23:0] last_out = '0;
    int          kw [5] = '{1, 4, 6, 4, 1};

    blur_5x5 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .input_pixel_R  (in_r),
        .input_pixel_G  (in_g),
        .input_pixel_B  (in_b),
        .output_pixel_R (out_r),
        .output_pixel_G (out_g),
        .output_pixel_B (out_b),
        .rd_flag        (rd_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] blur_ref(input int r, input int c);
        logic [23:0] res;
        int s;
        for (int ch = 0; ch < 3; ch++) begin
            s = 0;
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++)
                    s += kw[i] * kw[j] * int'(img[r-2+i][c-2+j][ch*8 +: 8]);
            res[ch*8 +: 8] = 8'((s + 128) / 256);
        end
        return res;
    endfunction

    // Drives npix pixels of the current image (npix<0 = whole frame) with 0..gmax idle cycles after each.
    task automatic send_frame(input int npix, input int gmax);
        exp_t e;
        int   k = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (k == npix) return;
                @(negedge clk);
                en = 1'b1;
                {in_b, in_g, in_r} = img[r][c];
                if (r >= 4 && c >= 4) begin
                    e.pix = blur_ref(r - 2, c - 2);
                    e.r   = r - 2;
                    e.c   = c - 2;
                    e.t   = cyc + 3;
                    sb.push_back(e);
                end
                k++;
                for (int g = $urandom_range(gmax, 0); g > 0; g--) begin
                    @(negedge clk);
                    en = 1'b0;
                end
            end
        end
    endtask

    task automatic drain(input int nexp);
        @(negedge clk);
        en = 1'b0;
        repeat (6) @(negedge clk);
        chk("drain_empty", sb.size(), 0);
        chk("out_count", n_out, nexp);
        n_out = 0;
    endtask

    task automatic fill_const(input logic [7:0] v);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = {v, v, v};
    endtask

    task automatic fill_rand();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = 24'($urandom);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            last_out = '0;
        end else if (rd_flag) begin
            if (sb.size() == 0) begin
                chk("spurious_rd", 1, 0);
            end else begin
                e_mon = sb.pop_front();
                chk("out_R", out_r, e_mon.pix[7:0]);
                chk("out_G", out_g, e_mon.pix[15:8]);
                chk("out_B", out_b, e_mon.pix[23:16]);
                chk("latency", cyc, e_mon.t);
                got_r[e_mon.r][e_mon.c] = out_r;
                n_out++;
            end
            last_out = {out_b, out_g, out_r};
        end else begin
            chk("hold", {out_b, out_g, out_r}, last_out);
        end
    end

    initial begin
        #1;
        chk("rst_rd", rd_flag, 0);
        chk("rst_out", {out_b, out_g, out_r}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        fill_const(8'd100);
        send_frame(-1, 0);
        drain(NOUT);

        fill_const(8'd0);
        img[4][6] = 24'h0000ff;
        send_frame(-1, 0);
        drain(NOUT);
        chk("imp_c", got_r[4][6], 36);
        chk("imp_h1", got_r[4][7], 24);
        chk("imp_d1", got_r[5][7], 16);
        chk("imp_d2", got_r[6][8], 1);
        chk("imp_v3", got_r[7][6], 0);

        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = (c < 8) ? 24'h0 : 24'hffffff;
        send_frame(-1, 0);
        drain(NOUT);
        chk("step5", got_r[4][5], 0);
        chk("step6", got_r[4][6], 16);
        chk("step7", got_r[4][7], 80);
        chk("step8", got_r[4][8], 175);
        chk("step9", got_r[4][9], 239);
        chk("step10", got_r[4][10], 255);

        fill_rand();
        send_frame(-1, 3);
        drain(NOUT);

        fill_rand();
        send_frame(-1, 0);
        fill_rand();
        send_frame(-1, 0);
        drain(2 * NOUT);

        fill_const(8'd100);
        send_frame(5 * W + 8, 0);
        @(posedge clk);
        #2;
        en    = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_rd", rd_flag, 0);
        chk("midrst_out", {out_b, out_g, out_r}, 0);
        sb.delete();
        n_out = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_frame(-1, 0);
        drain(NOUT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
